// File: rtl/hamming_sec_codec.sv
// Hamming(2^M-1, 2^M-1-M) single-error-correcting codec with programmable
// single-bit error injection, two-stage valid/ready pipeline and error counter.
module hamming_sec_codec #(
    parameter int M     = 4,
    parameter int CNT_W = 16,
    localparam int N    = (1 << M) - 1,
    localparam int K    = N - M
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_data,
    input  logic             inj_we,
    input  logic [M-1:0]     inj_pos,
    input  logic             inj_oneshot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_code,
    output logic [K-1:0]     out_data,
    output logic [M-1:0]     out_syndrome,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;

    // One-hot flip mask for a 1-based codeword position; position 0 means no flip.
    function automatic logic [N-1:0] pos_mask(input logic [M-1:0] pos);
        logic [N-1:0] m;
        m = '0;
        if (pos != '0) m[pos - 1'b1] = 1'b1;
        return m;
    endfunction

    function automatic logic [N-1:0] encode(input logic [K-1:0] d);
        logic [N-1:0] c;
        logic         par;
        int           k;
        c = '0;
        k = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[M'(p - 1)] = d[KW'(k)];
                k++;
            end
        end
        for (int i = 0; i < M; i++) begin
            par = 1'b0;
            for (int p = 1; p <= N; p++) begin
                if (((p >> i) & 1) != 0) par ^= c[M'(p - 1)];
            end
            c[M'((1 << i) - 1)] = par;
        end
        return c;
    endfunction

    function automatic logic [M-1:0] syndrome_of(input logic [N-1:0] c);
        logic [M-1:0] s;
        s = '0;
        for (int p = 1; p <= N; p++) begin
            if (c[M'(p - 1)]) s ^= M'(p);
        end
        return s;
    endfunction

    function automatic logic [K-1:0] data_of(input logic [N-1:0] c);
        logic [K-1:0] d;
        int           k;
        d = '0;
        k = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[KW'(k)] = c[M'(p - 1)];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [M-1:0]     inj_pos_q, inj_pos_d;
    logic             inj_os_q, inj_os_d;
    logic [N-1:0]     s1_code_q, s1_code_d;
    logic             s1_vld_q, s1_vld_d;
    logic [N-1:0]     out_code_q, out_code_d;
    logic [K-1:0]     out_data_q, out_data_d;
    logic [M-1:0]     out_syn_q, out_syn_d;
    logic             out_err_q, out_err_d;
    logic             out_vld_q, out_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load1, load2;
    logic [M-1:0]     s1_syn;

    always_comb begin
        load2    = s1_vld_q && (!out_vld_q || out_ready);
        in_ready = !reset && (!s1_vld_q || load2);
        load1    = in_valid && in_ready;

        // A oneshot injection retires with the word that used it; a new load overrides.
        inj_pos_d = inj_pos_q;
        inj_os_d  = inj_os_q;
        if (load1 && inj_os_q && (inj_pos_q != '0)) begin
            inj_pos_d = '0;
            inj_os_d  = 1'b0;
        end
        if (inj_we) begin
            inj_pos_d = inj_pos;
            inj_os_d  = inj_oneshot;
        end

        // Stage 0 -> S1: encode and inject
        s1_code_d = s1_code_q;
        s1_vld_d  = s1_vld_q;
        if (load1) begin
            s1_code_d = encode(in_data) ^ pos_mask(inj_pos_q);
            s1_vld_d  = 1'b1;
        end else if (load2) begin
            s1_vld_d  = 1'b0;
        end

        // S1 -> S2: syndrome decode and correction
        s1_syn     = syndrome_of(s1_code_q);
        out_code_d = out_code_q;
        out_data_d = out_data_q;
        out_syn_d  = out_syn_q;
        out_err_d  = out_err_q;
        out_vld_d  = out_vld_q;
        if (load2) begin
            out_code_d = s1_code_q;
            out_data_d = data_of(s1_code_q ^ pos_mask(s1_syn));
            out_syn_d  = s1_syn;
            out_err_d  = (s1_syn != '0);
            out_vld_d  = 1'b1;
        end else if (out_ready) begin
            out_vld_d  = 1'b0;
        end

        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (out_vld_q && out_ready && out_err_q) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inj_pos_q  <= '0;
            inj_os_q   <= 1'b0;
            s1_code_q  <= '0;
            s1_vld_q   <= 1'b0;
            out_code_q <= '0;
            out_data_q <= '0;
            out_syn_q  <= '0;
            out_err_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inj_pos_q  <= inj_pos_d;
            inj_os_q   <= inj_os_d;
            s1_code_q  <= s1_code_d;
            s1_vld_q   <= s1_vld_d;
            out_code_q <= out_code_d;
            out_data_q <= out_data_d;
            out_syn_q  <= out_syn_d;
            out_err_q  <= out_err_d;
            out_vld_q  <= out_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid    = out_vld_q;
    assign out_code     = out_code_q;
    assign out_data     = out_data_q;
    assign out_syndrome = out_syn_q;
    assign out_err      = out_err_q;
    assign err_count    = cnt_q;

endmodule

// File: tb/tb_hamming_sec_codec.sv
// Randomised and directed bench for hamming_sec_codec (M=4, CNT_W=4) against a
// transaction-level model: queue of expected words, known injected error position.
module tb_hamming_sec_codec;

    localparam int M     = 4;
    localparam int CNT_W = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [10:0]       in_data = '0;
    logic              inj_we = 1'b0;
    logic [3:0]        inj_pos = '0;
    logic              inj_oneshot = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [14:0]       out_code;
    logic [10:0]       out_data;
    logic [3:0]        out_syndrome;
    logic              out_err;
    logic [CNT_W-1:0]  err_count;
    logic              clr_count = 1'b0;

    hamming_sec_codec #(.M(M), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inj_we(inj_we), .inj_pos(inj_pos), .inj_oneshot(inj_oneshot),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_data(out_data), .out_syndrome(out_syndrome),
        .out_err(out_err), .err_count(err_count), .clr_count(clr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [14:0] code;
        logic [10:0] data;
        logic [3:0]  syn;
        logic        err;
        int          cyc;
    } word_t;

    word_t        exp_q[$];
    word_t        xlog[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic         last_acc = 1'b0;
    logic [3:0]   m_pos = '0;
    logic         m_os  = 1'b0;
    logic [3:0]   m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Parity bits are chosen so that the XOR of the positions of all set bits is zero.
    function automatic logic [14:0] ref_enc(input logic [10:0] d);
        logic [14:0] c;
        int          k;
        int          s;
        c = '0; k = 0; s = 0;
        for (int p = 1; p <= 15; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                if (d[k]) begin
                    c[p-1] = 1'b1;
                    s ^= p;
                end
                k++;
            end
        end
        for (int i = 0; i < 4; i++) if (s[i]) c[(1 << i) - 1] = 1'b1;
        return c;
    endfunction

    function automatic logic [14:0] ref_mask(input logic [3:0] pos);
        return (pos == 4'd0) ? 15'd0 : (15'd1 << (pos - 4'd1));
    endfunction

    // Called at a falling edge with inputs set; evaluates just before the next rising edge.
    task automatic cycle();
        word_t e;
        logic  exp_v;
        logic  xfer;
        logic  inc;
        #4;
        exp_v = 1'b0;
        if (exp_q.size() > 0) exp_v = (cyc - exp_q[0].cyc) >= 2;
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("in_ready", 32'(in_ready), 32'(!reset && (exp_q.size() < 2 || out_ready)));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        if (exp_v && out_valid) begin
            chk("out_code", 32'(out_code), 32'(exp_q[0].code));
            chk("out_data", 32'(out_data), 32'(exp_q[0].data));
            chk("out_syndrome", 32'(out_syndrome), 32'(exp_q[0].syn));
            chk("out_err", 32'(out_err), 32'(exp_q[0].err));
        end
        last_acc = in_valid && in_ready;
        xfer = out_valid && out_ready && (exp_q.size() > 0);
        inc = 1'b0;
        if (xfer) begin
            e = exp_q.pop_front();
            inc = e.err;
            e.code = out_code; e.data = out_data; e.syn = out_syndrome; e.err = out_err;
            e.cyc = cyc;
            xlog.push_back(e);
        end
        if (clr_count) m_cnt = '0;
        else if (inc && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        if (last_acc) begin
            e.code = ref_enc(in_data) ^ ref_mask(m_pos);
            e.data = in_data;
            e.syn  = m_pos;
            e.err  = (m_pos != 4'd0);
            e.cyc  = cyc;
            exp_q.push_back(e);
            if (m_os && m_pos != 4'd0) begin
                m_pos = '0;
                m_os  = 1'b0;
            end
        end
        if (inj_we) begin
            m_pos = inj_pos;
            m_os  = inj_oneshot;
        end
        cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send(input logic [10:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic load_inj(input logic [3:0] pos, input logic os);
        inj_we = 1'b1; inj_pos = pos; inj_oneshot = os;
        cycle();
        inj_we = 1'b0;
    endtask

    task automatic chk_log(input int idx, input logic [14:0] code, input logic [10:0] data,
                           input logic [3:0] syn, input logic err);
        if (xlog.size() <= idx) begin
            chk("log_size", 32'(xlog.size()), 32'(idx + 1));
        end else begin
            chk("log_code", 32'(xlog[idx].code), 32'(code));
            chk("log_data", 32'(xlog[idx].data), 32'(data));
            chk("log_syn", 32'(xlog[idx].syn), 32'(syn));
            chk("log_err", 32'(xlog[idx].err), 32'(err));
        end
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            cycle();
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_out_code", 32'(out_code), 32'd0);
        reset = 1'b0;
        idle(2);

        // No injection
        xlog.delete();
        send(11'h001);
        idle(3);
        chk_log(0, 15'h0007, 11'h001, 4'd0, 1'b0);

        // Sticky injection at position 5
        load_inj(4'd5, 1'b0);
        xlog.delete();
        send(11'h001);
        send(11'h7FF);
        idle(3);
        chk_log(0, 15'h0017, 11'h001, 4'd5, 1'b1);
        chk_log(1, 15'h7FEF, 11'h7FF, 4'd5, 1'b1);
        chk("tp2_count", 32'(err_count), 32'd2);

        // Oneshot injection at position 15
        load_inj(4'd15, 1'b1);
        xlog.delete();
        send(11'h7FF);
        send(11'h7FF);
        idle(3);
        chk_log(0, 15'h3FFF, 11'h7FF, 4'd15, 1'b1);
        chk_log(1, 15'h7FFF, 11'h7FF, 4'd0, 1'b0);
        chk("tp3_count", 32'(err_count), 32'd3);

        // Backpressure: two words buffered, third held off
        xlog.delete();
        out_ready = 1'b0;
        send(11'h0A5);
        send(11'h15A);
        in_valid = 1'b1;
        in_data  = 11'h3C3;
        repeat (3) begin
            cycle();
            chk("c_blocked", 32'(last_acc), 32'd0);
        end
        chk("rdy_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(11'h3C3);
        idle(4);
        chk_log(0, ref_enc(11'h0A5), 11'h0A5, 4'd0, 1'b0);
        chk_log(1, ref_enc(11'h15A), 11'h15A, 4'd0, 1'b0);
        chk_log(2, ref_enc(11'h3C3), 11'h3C3, 4'd0, 1'b0);
        if (xlog.size() >= 3) begin
            chk("bp_consec01", 32'(xlog[1].cyc - xlog[0].cyc), 32'd1);
            chk("bp_consec12", 32'(xlog[2].cyc - xlog[1].cyc), 32'd1);
        end else begin
            chk("bp_log_size", 32'(xlog.size()), 32'd3);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(3) != 0);
            in_data     = 11'($urandom);
            out_ready   = ($urandom_range(3) != 0);
            inj_we      = ($urandom_range(15) == 0);
            inj_pos     = 4'($urandom);
            inj_oneshot = 1'($urandom);
            clr_count   = ($urandom_range(31) == 0);
            cycle();
        end
        inj_we = 1'b0; clr_count = 1'b0; out_ready = 1'b1;
        idle(4);
        chk("drain", 32'(exp_q.size()), 32'd0);

        // Counter saturation and clear priority
        load_inj(4'd1, 1'b0);
        for (int i = 0; i < 20; i++) send(11'($urandom));
        idle(4);
        chk("sat_count", 32'(err_count), 32'd15);
        out_ready = 1'b0;
        send(11'($urandom));
        wait_valid();
        out_ready = 1'b1;
        clr_count = 1'b1;
        cycle();
        clr_count = 1'b0;
        chk("clr_prio", 32'(err_count), 32'd0);

        // Asynchronous reset with both stages full
        send(11'h0AA);
        idle(3);
        chk("pre_rst_count", 32'(err_count), 32'd1);
        out_ready = 1'b0;
        send(11'h111);
        send(11'h222);
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        m_cnt = '0; m_pos = '0; m_os = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        cycle();
        reset = 1'b0;
        xlog.delete();
        send(11'h123);
        idle(3);
        chk_log(0, ref_enc(11'h123), 11'h123, 4'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
